// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor: WIDTH is split into STAGES chunks,
// one chunk added per stage with the carry registered between stages.
module pipelined_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);
  localparam int CHUNK = WIDTH / STAGES;

  logic             advance;
  logic             out_valid_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_out_reg;
  logic             overflow_reg;

  // The whole pipe moves together; a full output register that is not taken stalls everything.
  assign advance   = !out_valid_reg || out_ready;
  assign in_ready  = advance;
  assign out_valid = out_valid_reg;
  assign sum       = sum_reg;
  assign carry_out = carry_out_reg;
  assign overflow  = overflow_reg;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam int BASE = gi * CHUNK;   // result bits already produced upstream
      localparam int REM  = WIDTH - BASE; // operand bits still to be consumed

      logic [REM-1:0]        a_in;
      logic [REM-1:0]        b_in;
      logic                  c_in;
      logic                  v_in;
      logic [BASE+CHUNK-1:0] s_next;
      logic [CHUNK:0]        chunk_sum;

      if (gi == 0) begin : g_head
        assign a_in   = a;
        assign b_in   = sub ? ~b : b;
        assign c_in   = sub | carry_in;
        assign v_in   = in_valid;
        assign s_next = chunk_sum[CHUNK-1:0];
      end else begin : g_body
        assign a_in   = g_stage[gi-1].g_mid.a_reg;
        assign b_in   = g_stage[gi-1].g_mid.b_reg;
        assign c_in   = g_stage[gi-1].g_mid.c_reg;
        assign v_in   = g_stage[gi-1].g_mid.v_reg;
        assign s_next = {chunk_sum[CHUNK-1:0], g_stage[gi-1].g_mid.s_reg};
      end

      assign chunk_sum = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]}
                       + {{CHUNK{1'b0}}, c_in};

      if (gi < STAGES - 1) begin : g_mid
        // Only the not-yet-added operand bits travel on; finished slices go into s_reg.
        logic [REM-CHUNK-1:0]  a_reg;
        logic [REM-CHUNK-1:0]  b_reg;
        logic [BASE+CHUNK-1:0] s_reg;
        logic                  c_reg;
        logic                  v_reg;

        always_ff @(posedge clk) begin
          if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            s_reg <= '0;
            c_reg <= 1'b0;
            v_reg <= 1'b0;
          end else if (advance) begin
            a_reg <= a_in[REM-1:CHUNK];
            b_reg <= b_in[REM-1:CHUNK];
            s_reg <= s_next;
            c_reg <= chunk_sum[CHUNK];
            v_reg <= v_in;
          end
        end
      end else begin : g_last
        logic carry_into_msb;

        // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ c.
        assign carry_into_msb = a_in[CHUNK-1] ^ b_in[CHUNK-1] ^ chunk_sum[CHUNK-1];

        always_ff @(posedge clk) begin
          if (rst) begin
            out_valid_reg <= 1'b0;
            sum_reg       <= '0;
            carry_out_reg <= 1'b0;
            overflow_reg  <= 1'b0;
          end else if (advance) begin
            out_valid_reg <= v_in;
            if (v_in) begin
              sum_reg       <= s_next;
              carry_out_reg <= chunk_sum[CHUNK];
              overflow_reg  <= carry_into_msb ^ chunk_sum[CHUNK];
            end
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub: the same directed vectors drive instances with
// STAGES = 4, 1, 2, 8, 16; each instance has its own expected queue and monitor.
module tb_pipelined_addsub;
  localparam int W    = 16;
  localparam int NDUT = 5;

  typedef struct {
    logic [W-1:0] sum;
    logic         co;
    logic         ov;
    int           acc_cyc;
    int           acc_stall;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           in_valid;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           carry_in;
  logic           sub;
  logic           out_ready;
  logic [W-1:0]   exp_sum;
  logic           exp_co;
  logic           exp_ov;

  logic [NDUT-1:0]        in_ready_w;
  logic [NDUT-1:0]        out_valid_w;
  logic [NDUT-1:0]        carry_w;
  logic [NDUT-1:0]        ovf_w;
  logic [NDUT-1:0][W-1:0] sum_w;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int main_pop_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  genvar gi;
  for (gi = 0; gi < NDUT; gi++) begin : g_dut
    localparam int ST = (gi == 0) ? 4 : (gi == 1) ? 1 : (gi == 2) ? 2 : (gi == 3) ? 8 : 16;

    exp_t         q[$];
    exp_t         e;
    int           stalls    = 0;
    bit           head_seen = 1'b0;
    logic [W-1:0] last_sum  = '0;
    logic         last_co   = 1'b0;
    logic         last_ov   = 1'b0;

    pipelined_addsub #(.WIDTH(W), .STAGES(ST)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready_w[gi]),
      .a         (a),
      .b         (b),
      .carry_in  (carry_in),
      .sub       (sub),
      .out_valid (out_valid_w[gi]),
      .out_ready (out_ready),
      .sum       (sum_w[gi]),
      .carry_out (carry_w[gi]),
      .overflow  (ovf_w[gi])
    );

    always @(negedge clk) begin
      if (rst) begin
        q.delete();
        head_seen = 1'b0;
        stalls    = 0;
        last_sum  = '0;
        last_co   = 1'b0;
        last_ov   = 1'b0;
      end else begin
        if (out_valid_w[gi]) begin
          if (q.size() == 0) begin
            check($sformatf("s%0d_spurious_out_valid", ST), out_valid_w[gi], 0);
          end else begin
            e = q[0];
            if (!head_seen) begin
              head_seen = 1'b1;
              check($sformatf("s%0d_latency", ST), cyc, e.acc_cyc + ST + (stalls - e.acc_stall));
            end
            check($sformatf("s%0d_sum", ST), sum_w[gi], e.sum);
            check($sformatf("s%0d_carry_out", ST), carry_w[gi], e.co);
            check($sformatf("s%0d_overflow", ST), ovf_w[gi], e.ov);
            if (out_ready) begin
              void'(q.pop_front());
              head_seen = 1'b0;
              last_sum  = e.sum;
              last_co   = e.co;
              last_ov   = e.ov;
            end else begin
              check($sformatf("s%0d_stall_in_ready", ST), in_ready_w[gi], 0);
            end
          end
        end else begin
          check($sformatf("s%0d_hold_sum", ST), sum_w[gi], last_sum);
          check($sformatf("s%0d_hold_flags", ST), {carry_w[gi], ovf_w[gi]}, {last_co, last_ov});
        end
        if (in_valid && in_ready_w[gi])
          q.push_back('{sum: exp_sum, co: exp_co, ov: exp_ov, acc_cyc: cyc, acc_stall: stalls});
        if (!in_ready_w[gi]) stalls++;
      end
    end
  end

  always @(negedge clk)
    if (!rst && out_valid_w[0] && out_ready) main_pop_cyc.push_back(cyc);

  function automatic int pending();
    return g_dut[0].q.size() + g_dut[1].q.size() + g_dut[2].q.size()
         + g_dut[3].q.size() + g_dut[4].q.size();
  endfunction

  // Directed vectors: a, b, carry_in, sub -> sum, carry_out, overflow (hand-computed).
  logic [W-1:0] t_a   [10] = '{16'h1234, 16'h1234, 16'hF000, 16'h8000, 16'h0000,
                               16'h5555, 16'h00FF, 16'h7FFF, 16'h0F0F, 16'h4000};
  logic [W-1:0] t_b   [10] = '{16'h1111, 16'h1111, 16'h1000, 16'h8000, 16'h0001,
                               16'h5555, 16'h0001, 16'hFFFF, 16'hF0F0, 16'h4000};
  logic         t_ci  [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic         t_sub [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [W-1:0] t_sum [10] = '{16'h2345, 16'h2346, 16'h0000, 16'h0000, 16'hFFFF,
                               16'h0000, 16'h0101, 16'h8000, 16'h0000, 16'h8000};
  logic         t_co  [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic         t_ov  [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  // Called just after a rising edge; returns just after the edge that took the vector.
  task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vci,
                      input logic vsub, input logic [W-1:0] es, input logic eco, input logic eov);
    int  n;
    bit  ok;
    n = 0;
    a = va; b = vb; carry_in = vci; sub = vsub;
    exp_sum = es; exp_co = eco; exp_ov = eov;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      ok = in_ready_w[0];
      @(posedge clk);
      #1;
      n++;
      if (ok) break;
      if (n > 100) begin
        total++;
        bad++;
        $display("FAIL send_timeout: in_ready stayed low for %0d cycles, required acceptance", n);
        break;
      end
    end
  endtask

  task automatic send_row(input int i);
    send(t_a[i], t_b[i], t_ci[i], t_sub[i], t_sum[i], t_co[i], t_ov[i]);
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      #1;
      if (pending() == 0) break;
    end
    check("drain_pending", pending(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; carry_in = 1'b0; sub = 1'b0;
    out_ready = 1'b1; exp_sum = '0; exp_co = 1'b0; exp_ov = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", out_valid_w, '0);
    check("reset_sum", sum_w[0], 16'h0000);
    check("reset_flags", {carry_w, ovf_w}, '0);
    check("reset_in_ready", in_ready_w, {NDUT{1'b1}});
    @(posedge clk);
    #1;

    // Carry ripple through every chunk, signed overflow both ways, borrow with carry_in ignored.
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0); drain();
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1); drain();
    send(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1); drain();
    send(16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0); drain();

    // Back-to-back stream: results must come out on consecutive cycles.
    main_pop_cyc.delete();
    for (int i = 0; i < 8; i++) send_row(i);
    drain();
    check("stream_count", main_pop_cyc.size(), 8);
    for (int i = 1; i < main_pop_cyc.size(); i++)
      check("stream_consecutive", main_pop_cyc[i] - main_pop_cyc[i-1], 1);

    // Backpressure mid-stream.
    fork
      begin
        for (int i = 0; i < 10; i++) send_row(i);
      end
      begin
        repeat (5) @(posedge clk);
        #2 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #2 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three operations in flight: nothing may emerge afterwards.
    send_row(0); send_row(3); send_row(7);
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("flush_out_valid", out_valid_w, '0);
    repeat (30) @(posedge clk);
    #1;
    check("flush_pending", pending(), 0);

    // Pipe still works after the flush.
    for (int i = 9; i >= 0; i--) send_row(i);
    drain();
    check("final_pending", pending(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
